data_sram_responder: RTL
========================

Name: data_sram_responder

Overview:
- Responder (slave) end of the CPU data-SRAM interface: consumes en/wen/addr/wdata, returns rdata one cycle later.
- Serves a byte-writable word RAM plus a small MMIO register window: LED, free-running timer, synchronised switches, scratch.
- Sits outside the CPU top as the simulation/FPGA data-side target; addresses arrive already translated to physical.

Parameters:
- ADDR_W, 12, word-index width of the RAM (2**ADDR_W 32-bit words; default 16 KB).
- MMIO_HI, 16'h1FAF, value of addr[31:16] that selects the MMIO window.

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- sram_en  in  1  access valid this cycle.
- sram_wen  in  4  byte write enables; 0 = read.
- sram_addr  in  32  physical byte address.
- sram_wdata  in  32  write data, already lane-aligned.
- sram_rdata  out  32  registered read data.
- led  out  16  LED register value.
- switch_in  in  8  asynchronous switch inputs.

Behaviour:
- Reset (async, resetn=0): sram_rdata=0, led=0, timer=0, scratch=0, switch sync flops=0. RAM array not reset; contents survive reset.
- Decode: addr[31:16]==MMIO_HI selects MMIO, else RAM. RAM index = addr[ADDR_W+1:2]; higher bits ignored, so RAM aliases/wraps. addr[1:0] always ignored.
- MMIO offsets (addr[15:0]):
  - 0xF000 LED: rw, low 16 bits; wen[1:0] used, wen[3:2] ignored.
  - 0xF020 TIMER: rw.
  - 0xF030 SWITCH: ro, {24'b0, sync}.
  - 0xF040 SCRATCH: rw, 32 bits.
  - Any other offset reads 0; writes are ignored.
- Write (en=1, wen!=0): for each i with wen[i]=1, byte i of the target <= wdata[8i+7:8i]; other bytes unchanged. en=0 means no write regardless of wen.
- Read latency: exactly 1 cycle. On every edge with en=1 (read or write), sram_rdata <= target word value before the edge (read-first). On edges with en=0, sram_rdata holds.
- Back-to-back: write to A at cycle n, read A at n+1 returns new data at n+2. Read and write in the same cycle returns old data.
- Timer:
  - 32-bit; +1 every cycle; 0xFFFFFFFF wraps to 0.
  - A write to TIMER loads the byte-merged value (merged against the current count) instead of incrementing that cycle; it resumes +1 on the next edge.
  - A read returns the pre-edge count.
- Switch: 2-flop synchroniser per bit; a read returns the synced value, so an input change is visible on the third edge after it occurs.
- Reset mid-access: the in-flight read result is lost (rdata=0); no partial write is performed on an edge where resetn=0.

Test Plan:
- Reset: drive resetn=0 mid-sim -> sram_rdata=0, led=0; read TIMER after release -> small count starting from 0.
- Byte write: write 0xAABBCCDD wen=4'hF to 0x00000100, then wen=4'b0010 wdata=0x00001100 -> read returns 0xAABB11DD one cycle after en.
- Read-first/back-to-back: write 0x12345678 to 0x200 and read 0x200 in the next cycle -> rdata 0x12345678; same-cycle overwrite with 0x0 -> that cycle's rdata is 0x12345678.
- Alias: with ADDR_W=12, write 0x55 to 0x00000004, read 0x00004004 -> 0x00000055. en=0 with wen=4'hF writes nothing.
- Timer: write 0xFFFFFFFE to 0x1FAFF020; reads on the following two edges -> 0xFFFFFFFE, then 0xFFFFFFFF; the read after that -> 0x00000000.
- MMIO: write 0x0000A5A5 to 0x1FAFF000 -> led=16'hA5A5 next cycle. switch_in=8'h3C -> read of 0x1FAFF030 ≥3 cycles later returns 0x0000003C. Read of 0x1FAFF010 -> 0.

Source files
------------

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: byte-writable word RAM plus a small MMIO window
// (LED, free-running timer, synchronised switches, scratch). Read data is
// registered and returned one cycle after the access (read-first).
module data_sram_responder #(
    parameter int          ADDR_W  = 12,
    parameter logic [15:0] MMIO_HI = 16'h1FAF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch_in
);

    // MMIO word offsets (addr[15:2]); the byte-lane bits never take part in decode
    localparam logic [13:0] OFF_LED     = 14'h3C00; // 0xF000
    localparam logic [13:0] OFF_TIMER   = 14'h3C08; // 0xF020
    localparam logic [13:0] OFF_SWITCH  = 14'h3C0C; // 0xF030
    localparam logic [13:0] OFF_SCRATCH = 14'h3C10; // 0xF040

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [31:0]       timer;
    logic [31:0]       scratch;
    logic [7:0]        sw_meta;
    logic [7:0]        sw_sync;
    logic [31:0]       mmio_rd;
    logic              is_mmio;
    logic              wr;
    logic [13:0]       off;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        unused_addr;

    assign is_mmio     = (sram_addr[31:16] == MMIO_HI);
    assign off         = sram_addr[15:2];
    assign idx         = sram_addr[ADDR_W+1:2];
    assign wr          = sram_en && (sram_wen != 4'b0000);
    assign unused_addr = sram_addr[1:0];

    // Byte-lane merge of write data over an existing word
    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // MMIO read mux; unmapped offsets read as zero
    always_comb begin
        mmio_rd = 32'h0;
        case (off)
            OFF_LED:     mmio_rd = {16'h0, led};
            OFF_TIMER:   mmio_rd = timer;
            OFF_SWITCH:  mmio_rd = {24'h0, sw_sync};
            OFF_SCRATCH: mmio_rd = scratch;
            default:     mmio_rd = 32'h0;
        endcase
    end

    // RAM byte writes; not reset, and gated so nothing lands while reset is held
    always_ff @(posedge clk) begin
        if (resetn && wr && !is_mmio)
            for (int i = 0; i < 4; i++)
                if (sram_wen[i]) mem[idx][8*i +: 8] <= sram_wdata[8*i +: 8];
    end

    // Registered read-first data; holds when no access is presented
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      sram_rdata <= 32'h0;
        else if (sram_en) sram_rdata <= is_mmio ? mmio_rd : mem[idx];
    end

    // LED register: only the low two byte lanes exist
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led <= 16'h0;
        end else if (wr && is_mmio && off == OFF_LED) begin
            if (sram_wen[0]) led[7:0]  <= sram_wdata[7:0];
            if (sram_wen[1]) led[15:8] <= sram_wdata[15:8];
        end
    end

    // Free-running timer; a write replaces the increment for that cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                timer <= 32'h0;
        else if (wr && is_mmio && off == OFF_TIMER) timer <= merge(timer, sram_wdata, sram_wen);
        else                                        timer <= timer + 32'd1;
    end

    // Scratch register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                  scratch <= 32'h0;
        else if (wr && is_mmio && off == OFF_SCRATCH) scratch <= merge(scratch, sram_wdata, sram_wen);
    end

    // Two-flop synchroniser for the asynchronous switch inputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_meta <= 8'h0;
            sw_sync <= 8'h0;
        end else begin
            sw_meta <= switch_in;
            sw_sync <= sw_meta;
        end
    end

endmodule
